// File: rtl/factorial_engine.sv
// Sequential factorial / double-factorial engine: one multiply per clock,
// start/done handshake, truncated result with a sticky per-run overflow flag.
module factorial_engine #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    localparam int PW = WIDTH + N_WIDTH + 1;
    localparam logic [WIDTH-1:0] ACC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] n_q, n_d;
    logic               mode_q, mode_d;
    logic [N_WIDTH:0]   i_q, i_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PW-1:0]      prod;
    logic [N_WIDTH:0]   step;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        mode_d     = mode_q;
        i_d        = i_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = done_q;

        // Full-width product so bits above WIDTH can feed the overflow flag.
        prod    = {{(N_WIDTH+1){1'b0}}, acc_q} * {{WIDTH{1'b0}}, i_q};
        step    = '0;
        step[0] = ~mode_q;
        step[1] = mode_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n;
                    mode_d  = mode;
                    acc_d   = ACC_ONE;
                    ovf_d   = 1'b0;
                    i_d     = '0;
                    i_d[1]  = 1'b1;
                    i_d[0]  = mode & n[0];
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (i_q <= {1'b0, n_q}) begin
                    acc_d = prod[WIDTH-1:0];
                    ovf_d = ovf_q | (|prod[PW-1:WIDTH]);
                    i_d   = i_q + step;
                end else begin
                    result_d   = acc_q;
                    overflow_d = ovf_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            mode_q     <= 1'b0;
            i_q        <= '0;
            acc_q      <= ACC_ONE;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            i_q        <= i_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Randomized and directed bench for factorial_engine against a product-of-terms model.
module tb_factorial_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  n = '0;
    logic        mode = 1'b0;
    logic        busy, done, overflow;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    factorial_engine #(.WIDTH(32), .N_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .mode(mode),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Multiplies the terms n, n-1 (or n-2), ... down to 2; overflow means the
    // exact product reached 2^32, m is the number of terms multiplied.
    function automatic void model(input int nn, input bit md,
                                  output logic [31:0] r, output logic o, output int m);
        longint unsigned p;
        r = 32'd1; o = 1'b0; m = 0;
        for (int k = nn; k >= 2; k -= (md ? 2 : 1)) begin
            p = {32'd0, r} * longint'(k);
            if ((p >> 32) != 0) o = 1'b1;
            r = p[31:0];
            m++;
        end
    endfunction

    task automatic run(input int nn, input bit md, output logic [31:0] r,
                       output logic o, output int cyc, output bit busy_ok);
        int g = 0;
        while (busy === 1'b1 && g < 600) begin @(posedge clk); #1; g++; end
        @(negedge clk);
        n = nn[7:0]; mode = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1 && done === 1'b0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 600) begin @(posedge clk); #1; cyc++; end
        r = result; o = overflow;
    endtask

    task automatic test_reset();
        #17;
        total++;
        if ({busy, done, overflow, result} !== 35'd0) begin
            bad++; $display("FAIL reset_hold got=%h want=0", {busy, done, overflow, result});
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done, overflow, result} !== 35'd0) begin
                bad++; $display("FAIL reset_idle cyc=%0d got=%h want=0", c, {busy, done, overflow, result});
            end
        end
    endtask

    task automatic test_factorial();
        logic [31:0] r; logic o; int cyc; bit bok;
        run(5, 0, r, o, cyc, bok);
        total++; if (!bok) begin bad++; $display("FAIL f5_busy got=%b want=1", busy); end
        total++; if (cyc !== 5) begin bad++; $display("FAIL f5_latency got=%0d want=5", cyc); end
        total++; if (r !== 32'd120 || o !== 1'b0) begin
            bad++; $display("FAIL f5_result got=%0d/%b want=120/0", r, o);
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL f5_done_pulse got=%b want=0", done); end
        repeat (3) @(posedge clk); #1;
        total++; if (result !== 32'd120) begin bad++; $display("FAIL f5_hold got=%0d want=120", result); end
        run(12, 0, r, o, cyc, bok);
        total++; if (r !== 32'd479001600 || o !== 1'b0 || cyc !== 12) begin
            bad++; $display("FAIL f12 got=%0d/%b/%0d want=479001600/0/12", r, o, cyc);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic o; int cyc; bit bok;
        run(13, 0, r, o, cyc, bok);
        total++; if (r !== 32'd1932053504 || o !== 1'b1) begin
            bad++; $display("FAIL f13 got=%0d/%b want=1932053504/1", r, o);
        end
        run(3, 0, r, o, cyc, bok);
        total++; if (r !== 32'd6 || o !== 1'b0) begin
            bad++; $display("FAIL f3_after_ovf got=%0d/%b want=6/0", r, o);
        end
    endtask

    task automatic test_double();
        logic [31:0] r; logic o; int cyc; bit bok;
        run(9, 1, r, o, cyc, bok);
        total++; if (r !== 32'd945 || cyc !== 5) begin
            bad++; $display("FAIL d9 got=%0d/%0d want=945/5", r, cyc);
        end
        run(10, 1, r, o, cyc, bok);
        total++; if (r !== 32'd3840 || cyc !== 6) begin
            bad++; $display("FAIL d10 got=%0d/%0d want=3840/6", r, cyc);
        end
        for (int k = 0; k < 2; k++) begin
            run(k, 1, r, o, cyc, bok);
            total++; if (r !== 32'd1 || o !== 1'b0 || cyc !== 1) begin
                bad++; $display("FAIL d%0d got=%0d/%b/%0d want=1/0/1", k, r, o, cyc);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] r; logic o; int cyc; bit bok;
        logic [31:0] er; logic eo; int em;
        model(255, 0, er, eo, em);
        run(255, 0, r, o, cyc, bok);
        total++; if (r !== er || o !== 1'b1 || cyc !== 255) begin
            bad++; $display("FAIL f255 got=%h/%b/%0d want=%h/1/255", r, o, cyc, er);
        end
        model(255, 1, er, eo, em);
        run(255, 1, r, o, cyc, bok);
        total++; if (r !== er || o !== eo || cyc !== em + 1) begin
            bad++; $display("FAIL d255 got=%h/%b/%0d want=%h/%b/%0d", r, o, cyc, er, eo, em + 1);
        end
        run(0, 0, r, o, cyc, bok);
        total++; if (r !== 32'd1 || o !== 1'b0 || cyc !== 1) begin
            bad++; $display("FAIL f0 got=%0d/%b/%0d want=1/0/1", r, o, cyc);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc = 0;
        int g = 0;
        while (busy === 1'b1 && g < 600) begin @(posedge clk); #1; g++; end
        @(negedge clk);
        n = 8'd10; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 600) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 2) begin start = 1'b1; n = 8'd3; mode = 1'b1; end
            if (cyc == 4) start = 1'b0;
        end
        total++; if (result !== 32'd3628800 || overflow !== 1'b0 || cyc !== 10) begin
            bad++; $display("FAIL busy_ignore got=%0d/%b/%0d want=3628800/0/10", result, overflow, cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic o; int cyc; bit bok;
        int seen = 0;
        int g = 0;
        while (busy === 1'b1 && g < 600) begin @(posedge clk); #1; g++; end
        @(negedge clk);
        n = 8'd10; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({busy, done, overflow, result} !== 35'd0) begin
            bad++; $display("FAIL rst_mid got=%h want=0", {busy, done, overflow, result});
        end
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
            if (c == 2) rst = 1'b0;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", seen); end
        run(7, 0, r, o, cyc, bok);
        total++; if (r !== 32'd5040 || o !== 1'b0 || cyc !== 7) begin
            bad++; $display("FAIL after_rst got=%0d/%b/%0d want=5040/0/7", r, o, cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er; logic o, eo; int cyc, em; bit bok;
        int nn; bit md;
        for (int t = 0; t < 30; t++) begin
            nn = ($urandom_range(0, 5) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 40));
            md = 1'($urandom_range(0, 1));
            model(nn, md, er, eo, em);
            run(nn, md, r, o, cyc, bok);
            total++; if (r !== er || o !== eo || cyc !== em + 1 || !bok) begin
                bad++; $display("FAIL rand n=%0d mode=%0d got=%h/%b/%0d want=%h/%b/%0d",
                                nn, md, r, o, cyc, er, eo, em + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_factorial();
        test_overflow();
        test_double();
        test_boundary();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
